imm_extend_pipe: RTL
====================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter IMM_W, default 20: width of the raw immediate field.
REQ-002 SHALL have parameter HALF_W, default 16: width of the short immediate used by modes 00/01.
REQ-003 SHALL have parameter DATA_W, default 32: width of the extended result.
REQ-004 SHALL have parameter SHIFT_AMT, default 2: left-shift distance for mode 11.
REQ-005 Port clk_i, in, 1: single clock; all state on rising edge.
REQ-006 Port rst_i, in, 1: reset, asynchronous and active-high.
REQ-007 Port valid_i, in, 1: input request valid.
REQ-008 Port ready_o, out, 1: block can accept a request.
REQ-009 Port ext_sel_i, in, 2: extension mode.
REQ-010 Port imm_i, in, IMM_W: raw immediate bits.
REQ-011 Port valid_o, out, 1: result valid.
REQ-012 Port ready_i, in, 1: consumer accepts result.
REQ-013 Port imm_ext_o, out, DATA_W: extended immediate.
REQ-014 Port illegal_o, out, 1: sticky flag, an undefined mode was accepted.
REQ-015 Port clear_i, in, 1: synchronous clear of illegal_o.

Function
REQ-016 Mode 00 SHALL zero-extend imm_i[HALF_W-1:0] to DATA_W.
REQ-017 Mode 01 SHALL sign-extend imm_i[HALF_W-1:0] from bit HALF_W-1.
REQ-018 Mode 10 SHALL sign-extend all IMM_W bits from bit IMM_W-1.
REQ-019 Mode 11 SHALL behave per REQ-031/REQ-032.
REQ-020 An input transfer SHALL occur when valid_i and ready_o are both high at a rising edge.
REQ-021 An output transfer SHALL occur when valid_o and ready_i are both high at a rising edge.
REQ-022 Latency SHALL be one cycle: a result accepted at edge N appears on valid_o/imm_ext_o after edge N when the output stage is empty or draining.
REQ-023 Storage SHALL be a 2-entry skid buffer (output register + skid register); ready_o SHALL be registered and low only when the skid entry is occupied.
REQ-024 States SHALL be EMPTY (0 entries), ONE (output only), FULL (output + skid). EMPTY->ONE on input transfer. ONE->EMPTY on output transfer without input. ONE->FULL on input without output. ONE->ONE on both. FULL->ONE on output transfer, skid moving to output.
REQ-025 No input transfer is possible in FULL, because ready_o is low.
REQ-026 Results SHALL leave in acceptance order with no loss or duplication.
REQ-027 imm_ext_o and valid_o SHALL remain stable while valid_o=1 and ready_i=0.
REQ-028 illegal_o SHALL set on the edge after a mode-11 transfer when SHIFT_EN is absent. clear_i SHALL clear it. Simultaneous set and clear SHALL leave it set.

Reset
REQ-029 rst_i SHALL force EMPTY: valid_o=0, ready_o=1, imm_ext_o=0, illegal_o=0.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered entries. The first post-reset transfer starts from EMPTY.

Configuration
REQ-031 With macro IMM_EXT_SHIFT_EN defined, mode 11 SHALL produce (sign-extend IMM_W bits) << SHIFT_AMT, truncated to DATA_W, and SHALL NOT set illegal_o.
REQ-032 Without IMM_EXT_SHIFT_EN, mode 11 SHALL produce 0 and set illegal_o.

Structure
REQ-033 A shared package imm_ext_pkg SHALL hold the mode typedef (EXT_ZERO=00, EXT_SIGN=01, EXT_SIGN_LONG=10, EXT_SIGN_SHL=11) and the buffer-state typedef.
REQ-034 A combinational sub-module imm_ext_core SHALL compute the extension; imm_extend_pipe SHALL hold the buffer, FSM and flag.
REQ-035 Elaboration SHALL fail when HALF_W > IMM_W or IMM_W > DATA_W.

Verification
REQ-036 Defaults, ready_i=1; send mode 00 imm=0x08001 -> next cycle imm_ext_o=0x00008001.
REQ-037 Mode 01 imm=0x08001 -> 0xFFFF8001; mode 10 imm=0x80001 -> 0xFFF80001.
REQ-038 ready_i=0; send three requests -> ready_o low after the second; release ready_i -> results 1,2,3 in order, none lost.
REQ-039 Mode 11 imm=0x00003: with IMM_EXT_SHIFT_EN -> 0x0000000C, illegal_o=0; without it -> 0x00000000, illegal_o=1; then clear_i -> illegal_o=0.
REQ-040 Reset in FULL -> valid_o=0, ready_o=1 immediately; next request mode 00 imm=0x00005 -> 0x00000005 alone.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate-extension pipeline: extension modes and
// skid-buffer occupancy states.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO      = 2'b00,
        EXT_SIGN      = 2'b01,
        EXT_SIGN_LONG = 2'b10,
        EXT_SIGN_SHL  = 2'b11
    } ext_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender. Mode 11 is a shifted long sign-extension
// when IMM_EXT_SHIFT_EN is defined, otherwise it yields 0 and flags illegal.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IMM_W     = 20,
    parameter int HALF_W    = 16,
    parameter int DATA_W    = 32,
    parameter int SHIFT_AMT = 2
) (
    input  logic [1:0]        ext_sel_i,
    input  logic [IMM_W-1:0]  imm_i,
    output logic [DATA_W-1:0] imm_ext_o,
    output logic              illegal_o
);

    ext_mode_e mode;
    assign mode = ext_mode_e'(ext_sel_i);

`ifdef IMM_EXT_SHIFT_EN
    logic [DATA_W-1:0] long_ext;
    assign long_ext = DATA_W'($signed(imm_i));
`endif

    always_comb begin
        imm_ext_o = '0;
        illegal_o = 1'b0;
        unique case (mode)
            EXT_ZERO:      imm_ext_o = DATA_W'(imm_i[HALF_W-1:0]);
            EXT_SIGN:      imm_ext_o = DATA_W'($signed(imm_i[HALF_W-1:0]));
            EXT_SIGN_LONG: imm_ext_o = DATA_W'($signed(imm_i));
            EXT_SIGN_SHL: begin
`ifdef IMM_EXT_SHIFT_EN
                imm_ext_o = long_ext << SHIFT_AMT;
`else
                imm_ext_o = '0;
                illegal_o = 1'b1;
`endif
            end
            default: imm_ext_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender behind a 2-entry skid buffer (output reg + skid reg).
// Optional mode-11 shift feature is enabled by defining IMM_EXT_SHIFT_EN.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IMM_W     = 20,
    parameter int HALF_W    = 16,
    parameter int DATA_W    = 32,
    parameter int SHIFT_AMT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        ext_sel_i,
    input  logic [IMM_W-1:0]  imm_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] imm_ext_o,
    output logic              illegal_o,
    input  logic              clear_i,
    output logic [1:0]        state_o
);

    if (HALF_W > IMM_W || IMM_W > DATA_W) begin : g_bad_params
        $error("imm_extend_pipe: require HALF_W <= IMM_W <= DATA_W");
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; once valid_o is up, imm_ext_o/valid_o hold until accepted.

    buf_state_e        state_q, state_d;
    logic [DATA_W-1:0] out_q, skid_q, ext_data;
    logic              ext_illegal;
    logic              ready_q, illegal_q;
    logic              in_xfer, out_xfer;
    logic              load_out_in, load_out_skid, load_skid;

    imm_ext_core #(
        .IMM_W    (IMM_W),
        .HALF_W   (HALF_W),
        .DATA_W   (DATA_W),
        .SHIFT_AMT(SHIFT_AMT)
    ) u_core (
        .ext_sel_i(ext_sel_i),
        .imm_i    (imm_i),
        .imm_ext_o(ext_data),
        .illegal_o(ext_illegal)
    );

    assign in_xfer  = valid_i && ready_q;
    assign out_xfer = valid_o && ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL);
        end
    end

    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d     = ST_ONE;
                    load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_out_in = 1'b1;
                end else if (in_xfer) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // ready_o is low here, so only the drain path can fire
                if (out_xfer) begin
                    state_d       = ST_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        valid_o   = (state_q != ST_EMPTY);
        ready_o   = ready_q;
        imm_ext_o = out_q;
        illegal_o = illegal_q;
        state_o   = state_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_in)        out_q  <= ext_data;
            else if (load_out_skid) out_q  <= skid_q;
            if (load_skid)          skid_q <= ext_data;
        end
    end

    // Set wins over a simultaneous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                        illegal_q <= 1'b0;
        else if (in_xfer && ext_illegal)  illegal_q <= 1'b1;
        else if (clear_i)                 illegal_q <= 1'b0;
    end

endmodule
